fa_serial_add_ctrl: RTL
=======================

// Module: fa_serial_add_ctrl
// PURPOSE
//  Sequencer that time-shares one 1-bit full-adder cell (fa_nand) to add two
//  WIDTH-bit operands bit-serially, LSB first, one bit per clock.
//  Sits between a requester (start/done handshake) and the adder cell.
//  Trades WIDTH+1 cycles of latency for a single adder instance.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk    in   1      rising-edge clock; the only clock
//  rst    in   1      synchronous reset, active-high
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A; sampled on the accepting edge
//  b      in   WIDTH  operand B; sampled on the accepting edge
//  cin    in   1      carry-in; sampled on the accepting edge
//  busy   out  1      high whenever state != IDLE
//  done   out  1      one-cycle pulse: result valid
//  sum    out  WIDTH  registered result; held until the next result is loaded
//  cout   out  1      registered carry-out; held with sum
// BEHAVIOUR
//  Reset: on any edge with rst=1 -> state=IDLE; busy, done, sum, cout,
//   shift regs, carry and bit counter all 0. rst has priority over every
//   other input, including mid-operation (the operation is abandoned, no done).
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 at edge -> a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, ->RUN.
//         start=0 -> stay in IDLE.
//   RUN : the cell is driven with a_sh[0], b_sh[0], carry. Each edge:
//         res_sh<={fa_sum,res_sh[WIDTH-1:1]}; a_sh,b_sh>>=1; carry<=fa_cout;
//         cnt<=cnt+1. Edge with cnt==WIDTH-1 -> ->DONE, and sum<= the final
//         shifted value (including this bit), cout<=fa_cout.
//   DONE: done=1 for exactly this cycle; next edge -> IDLE unconditionally.
//  start is ignored (not queued) in RUN and DONE; a, b and cin may change
//   freely after the accepting edge.
//  Latency: with start accepted at edge E0, done is high in the cycle after
//   edge E0+WIDTH (WIDTH RUN edges). Next start is accepted no earlier than
//   the edge leaving DONE+1, i.e. the cycle after done deasserts
//   (throughput 1 op / WIDTH+2 cycles).
//  done and busy are decoded from registered state, not from start.
//  Arithmetic: {cout,sum} == a + b + cin exactly, modulo 2^(WIDTH+1);
//   no overflow flag.
//  cnt width = $clog2(WIDTH); cnt never wraps in RUN (exit at WIDTH-1).
//  sum/cout change only on the edge entering DONE or on reset.
//  The cell input mux drives 0s outside RUN (no X propagation).
// TESTING (WIDTH=8 unless noted; check busy/done cycle-exact)
//  1 reset 2 cycles -> busy=0, done=0, sum=0x00, cout=0.
//  2 a=0x5A b=0x3C cin=0 start 1 cycle -> busy 9 cycles, done pulse in the
//    9th cycle after the start edge, sum=0x96, cout=0.
//  3 a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1; a=0xFF b=0xFF cin=1 ->
//    sum=0xFF cout=1 (full carry-chain ripple).
//  4 start held high throughout plus a,b changed during RUN -> exactly one op
//    per WIDTH+2 cycles, results match the values sampled at each accepting edge.
//  5 rst asserted at RUN cycle 4 -> next cycle IDLE, busy=0, no done pulse,
//    sum/cout=0; a new start afterwards completes correctly.
//  6 WIDTH=2: exhaustive 32 {a,b,cin} combos vs reference a+b+cin.

Source files
------------

// File: rtl/fa_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// fa_serial_add_ctrl
//
// Purpose:
//   Adds two WIDTH-bit operands bit-serially, LSB first, one bit per clock.
//   All bits go through a single 1-bit full-adder cell (fa_nand).
//   A requester raises start; the block answers with a one-cycle done pulse
//   and a registered {cout, sum}.
//   An operation occupies the block for WIDTH+2 cycles: WIDTH RUN cycles,
//   one DONE cycle and one IDLE cycle.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous reset, active-high; overrides everything
//   start  in   1      request, sampled only while IDLE
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   busy   out  1      high whenever the sequencer is not IDLE
//   done   out  1      one-cycle pulse: sum/cout hold a fresh result
//   sum    out  WIDTH  registered result, held until the next result
//   cout   out  1      registered carry-out, held with sum
//
// Also contains fa_nand, the 1-bit full adder built from 2-input NANDs.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// fa_nand: 1-bit full adder from nine 2-input NAND gates.
//   a, b, ci in  -> s = a ^ b ^ ci, co = majority(a, b, ci)
// ---------------------------------------------------------------------------
module fa_nand (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic n1, n2, n3, x1, n4, n5, n6;

    assign n1 = ~(a & b);
    assign n2 = ~(a & n1);
    assign n3 = ~(b & n1);
    assign x1 = ~(n2 & n3);      // a ^ b
    assign n4 = ~(x1 & ci);
    assign n5 = ~(x1 & n4);
    assign n6 = ~(ci & n4);
    assign s  = ~(n5 & n6);      // a ^ b ^ ci
    assign co = ~(n4 & n1);      // (a & b) | (ci & (a ^ b))
endmodule

module fa_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    // Holds the result bits produced so far. Only WIDTH-1 bits are needed:
    // the last bit goes straight from the cell into sum.
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic             fa_a, fa_b, fa_ci;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] res_next;

    // Cell inputs are forced to 0 outside RUN so that stale shift-register
    // contents never toggle the adder.
    assign fa_a  = (state_q == ST_RUN) ? a_sh_q[0] : 1'b0;
    assign fa_b  = (state_q == ST_RUN) ? b_sh_q[0] : 1'b0;
    assign fa_ci = (state_q == ST_RUN) ? carry_q   : 1'b0;

    fa_nand u_fa (
        .a  (fa_a),
        .b  (fa_b),
        .ci (fa_ci),
        .s  (fa_s),
        .co (fa_co)
    );

    // New bit enters at the top; after WIDTH shifts bit 0 is the LSB.
    assign res_next = {fa_s, res_sh_q};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_sh_d = res_next[WIDTH-1:1];
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_co;
                if (cnt_q == CNT_LAST) begin
                    // Counter stays at its last value instead of wrapping.
                    state_d = ST_DONE;
                    sum_d   = res_next;
                    cout_d  = fa_co;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule
